// File: rtl/axil_cmd_arbiter_if.sv
// rtl/axil_cmd_arbiter_if.sv - requester, command and B/R tap bundle for axil_cmd_arbiter
interface axil_cmd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [1:0]                    rsp_resp;
    logic                          rsp_timeout;
    logic                          busy;
    logic [ID_W-1:0]               grant_id;
    logic                          write;
    logic [ADDR_WIDTH-1:0]         write_address;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          read;
    logic [ADDR_WIDTH-1:0]         read_address;
    logic                          m_axi_bvalid;
    logic                          m_axi_bready;
    logic [1:0]                    m_axi_bresp;
    logic                          m_axi_rvalid;
    logic                          m_axi_rready;
    logic [DATA_WIDTH-1:0]         m_axi_rdata;
    logic [1:0]                    m_axi_rresp;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  m_axi_bvalid, m_axi_bready, m_axi_bresp,
        input  m_axi_rvalid, m_axi_rready, m_axi_rdata, m_axi_rresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy, grant_id,
        output write, write_address, write_data, read, read_address
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output m_axi_bvalid, m_axi_bready, m_axi_bresp,
        output m_axi_rvalid, m_axi_rready, m_axi_rdata, m_axi_rresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy, grant_id,
        input  write, write_address, write_data, read, read_address
    );
endinterface

// File: rtl/axil_cmd_arbiter.sv
// rtl/axil_cmd_arbiter.sv - round-robin arbiter sharing one axil_master command port
// One command outstanding at a time; completion from the B/R taps or a WAIT timeout.
module axil_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_areset,
    axil_cmd_arbiter_if.slave    bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  tmo_q, tmo_d;

    logic                  found;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       idx;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [NUM_REQ-1:0]    grant_oh;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_write = bus.req_write[i];
                win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = win;
                    wr_d    = win_write;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A real handshake beats the timeout when both land together.
                if (wr_q && bus.m_axi_bvalid && bus.m_axi_bready) begin
                    rdata_d = '0;
                    resp_d  = bus.m_axi_bresp;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (!wr_q && bus.m_axi_rvalid && bus.m_axi_rready) begin
                    rdata_d = bus.m_axi_rdata;
                    resp_d  = bus.m_axi_rresp;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rdata_d = '0;
                    resp_d  = 2'b10;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_oh          = NUM_REQ'(1) << grant_q;
    assign bus.req_ready     = (state_q == S_ISSUE) ? grant_oh : '0;
    assign bus.rsp_valid     = (state_q == S_RESP) ? grant_oh : '0;
    assign bus.write         = (state_q == S_ISSUE) && wr_q;
    assign bus.read          = (state_q == S_ISSUE) && !wr_q;
    assign bus.write_address = addr_q;
    assign bus.write_data    = wdata_q;
    assign bus.read_address  = addr_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_resp      = resp_q;
    assign bus.rsp_timeout   = tmo_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.grant_id      = grant_q;
endmodule

// File: tb/tb_axil_cmd_arbiter.sv
// tb/tb_axil_cmd_arbiter.sv - directed self-checking bench for axil_cmd_arbiter
module tb_axil_cmd_arbiter;
    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_cmd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axil_cmd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .bus          (bus)
    );

    task automatic post_req(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[id]        = 1'b1;
        bus.req_write[id]        = wr;
        bus.req_addr[id*AW +: AW]  = a;
        bus.req_wdata[id*DW +: DW] = d;
    endtask

    task automatic wait_ready(output logic [NR-1:0] rdy, output int gnt, output logic wp,
                              output logic rp, output int at_cyc);
        rdy = '0; gnt = -1; wp = 1'b0; rp = 1'b0; at_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                rdy = bus.req_ready; gnt = int'(bus.grant_id);
                wp = bus.write; rp = bus.read; at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic finish_cmd(input bit wr, input logic [DW-1:0] rd, input logic [1:0] resp, input int delay,
                              output logic pulse_after, output logic [NR-1:0] rv, output logic [DW-1:0] rdat,
                              output logic [1:0] rr, output logic rt);
        @(negedge clk);
        pulse_after = bus.write | bus.read;
        repeat (delay) @(negedge clk);
        if (wr) begin
            bus.m_axi_bvalid = 1'b1; bus.m_axi_bready = 1'b1; bus.m_axi_bresp = resp;
        end else begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rready = 1'b1; bus.m_axi_rdata = rd; bus.m_axi_rresp = resp;
        end
        @(negedge clk);
        rv = bus.rsp_valid; rdat = bus.rsp_rdata; rr = bus.rsp_resp; rt = bus.rsp_timeout;
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bready = 1'b0; bus.m_axi_bresp = 2'b00;
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", bus.req_ready); else pass_cnt++;
        total_cnt++; if ({bus.write, bus.read} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {bus.write, bus.read}); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b exp 0000", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.write_address !== 24'h0) $display("FAIL reset_waddr got %h exp 000000", bus.write_address); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [NR-1:0] rdy, rv; int g, c; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        post_req(0, 1'b1, 24'h000004, 32'h55555555);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (rdy !== 4'b0001) $display("FAIL wr_ready got %b exp 0001", rdy); else pass_cnt++;
        total_cnt++; if ({wp, rp} !== 2'b10) $display("FAIL wr_pulse got %b exp 10", {wp, rp}); else pass_cnt++;
        total_cnt++; if (bus.write_address !== 24'h000004) $display("FAIL wr_addr got %h exp 000004", bus.write_address); else pass_cnt++;
        total_cnt++; if (bus.write_data !== 32'h55555555) $display("FAIL wr_data got %h exp 55555555", bus.write_data); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        finish_cmd(1'b1, 32'h0, 2'b00, 0, pa, rv, rd, rr, rt);
        total_cnt++; if (pa !== 1'b0) $display("FAIL wr_pulse_width got %b exp 0", pa); else pass_cnt++;
        total_cnt++; if (rv !== 4'b0001) $display("FAIL wr_rsp_valid got %b exp 0001", rv); else pass_cnt++;
        total_cnt++; if ({rr, rt} !== 3'b000) $display("FAIL wr_rsp got %b exp 000", {rr, rt}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0) $display("FAIL wr_idle got busy %b rsp %b exp 0 0000", bus.busy, bus.rsp_valid); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [NR-1:0] rdy, rv; int g, c; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        post_req(1, 1'b1, 24'h000100, 32'h12345678);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (rdy !== 4'b0010) $display("FAIL wr1_ready got %b exp 0010", rdy); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        finish_cmd(1'b1, 32'h0, 2'b00, 1, pa, rv, rd, rr, rt);
        total_cnt++; if (rv !== 4'b0010) $display("FAIL wr1_rsp_valid got %b exp 0010", rv); else pass_cnt++;
        post_req(2, 1'b0, 24'h000100, 32'h0);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (rdy !== 4'b0100) $display("FAIL rd2_ready got %b exp 0100", rdy); else pass_cnt++;
        total_cnt++; if ({wp, rp} !== 2'b01) $display("FAIL rd2_pulse got %b exp 01", {wp, rp}); else pass_cnt++;
        total_cnt++; if (bus.read_address !== 24'h000100) $display("FAIL rd2_addr got %h exp 000100", bus.read_address); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        finish_cmd(1'b0, 32'h12345678, 2'b00, 2, pa, rv, rd, rr, rt);
        total_cnt++; if (rv !== 4'b0100) $display("FAIL rd2_rsp_valid got %b exp 0100", rv); else pass_cnt++;
        total_cnt++; if (rd !== 32'h12345678) $display("FAIL rd2_rdata got %h exp 12345678", rd); else pass_cnt++;
        total_cnt++; if ({rr, rt} !== 3'b000) $display("FAIL rd2_rsp got %b exp 000", {rr, rt}); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] rdy, rv, e; int g, c; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        int exp_a[3] = '{0, 1, 2};
        int exp_b[2] = '{0, 2};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) post_req(i, 1'b0, AW'(32'h10 * i), 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ready(rdy, g, wp, rp, c);
            e = NR'(1) << exp_a[k];
            total_cnt++; if (g !== exp_a[k] || rdy !== e) $display("FAIL rr_a%0d grant got %0d/%b exp %0d/%b", k, g, rdy, exp_a[k], e); else pass_cnt++;
            bus.req_valid = (rdy == '0) ? '0 : (bus.req_valid & ~rdy);
            finish_cmd(1'b0, 32'hA0 + k, 2'b00, 0, pa, rv, rd, rr, rt);
            total_cnt++; if (rv !== e || rd !== 32'hA0 + k) $display("FAIL rr_a%0d rsp got %b/%h exp %b/%h", k, rv, rd, e, 32'hA0 + k); else pass_cnt++;
        end
        post_req(0, 1'b0, 24'h000050, 32'h0);
        post_req(2, 1'b0, 24'h000060, 32'h0);
        for (int k = 0; k < 2; k++) begin
            wait_ready(rdy, g, wp, rp, c);
            e = NR'(1) << exp_b[k];
            total_cnt++; if (g !== exp_b[k] || rdy !== e) $display("FAIL rr_b%0d grant got %0d/%b exp %0d/%b", k, g, rdy, exp_b[k], e); else pass_cnt++;
            bus.req_valid = (rdy == '0) ? '0 : (bus.req_valid & ~rdy);
            finish_cmd(1'b0, 32'hB0 + k, 2'b00, 0, pa, rv, rd, rr, rt);
        end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rdy, rv; int g, c, n; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        logic [NR-1:0] stray;
        post_req(3, 1'b1, 24'h000020, 32'hCAFEF00D);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (rdy !== 4'b1000) $display("FAIL to_ready got %b exp 1000", rdy); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        n = -1; rv = '0; rd = '1; rr = 2'b00; rt = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                n = k; rv = bus.rsp_valid; rd = bus.rsp_rdata; rr = bus.rsp_resp; rt = bus.rsp_timeout;
                break;
            end
            if (k == 3) begin
                bus.m_axi_rvalid = 1'b1; bus.m_axi_rready = 1'b1; bus.m_axi_rdata = 32'hDEADBEEF;
            end
            if (k == 4) begin
                bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rdata = '0;
            end
        end
        total_cnt++; if (n !== TO + 2) $display("FAIL to_latency got %0d exp %0d", n, TO + 2); else pass_cnt++;
        total_cnt++; if (rv !== 4'b1000) $display("FAIL to_rsp_valid got %b exp 1000", rv); else pass_cnt++;
        total_cnt++; if ({rr, rt} !== 3'b101 || rd !== 32'h0) $display("FAIL to_rsp got %b/%h exp 101/00000000", {rr, rt}, rd); else pass_cnt++;
        bus.m_axi_bvalid = 1'b1; bus.m_axi_bready = 1'b1; bus.m_axi_bresp = 2'b00;
        stray = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stray = stray | bus.rsp_valid;
            bus.m_axi_bvalid = 1'b0; bus.m_axi_bready = 1'b0;
        end
        total_cnt++; if (stray !== 4'b0000) $display("FAIL to_stray_b got %b exp 0000", stray); else pass_cnt++;
        total_cnt++; if ({bus.rsp_resp, bus.rsp_timeout} !== 3'b101) $display("FAIL to_hold got %b exp 101", {bus.rsp_resp, bus.rsp_timeout}); else pass_cnt++;
        post_req(0, 1'b1, 24'h000040, 32'h00000001);
        wait_ready(rdy, g, wp, rp, c);
        bus.req_valid = bus.req_valid & ~rdy;
        finish_cmd(1'b1, 32'h0, 2'b01, TO, pa, rv, rd, rr, rt);
        total_cnt++; if (rv !== 4'b0001) $display("FAIL to_edge_valid got %b exp 0001", rv); else pass_cnt++;
        total_cnt++; if ({rr, rt} !== 3'b010) $display("FAIL to_edge_rsp got %b exp 010", {rr, rt}); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        logic [NR-1:0] rdy, rv, stray; int g, c; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        post_req(1, 1'b0, 24'h000ABC, 32'h0);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (g !== 1) $display("FAIL rst_pre_grant got %0d exp 1", g); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (bus.busy !== 1'b0 || bus.read !== 1'b0) $display("FAIL rst_async got busy %b read %b exp 0 0", bus.busy, bus.read); else pass_cnt++;
        total_cnt++; if (bus.grant_id !== 2'd0 || bus.read_address !== 24'h0) $display("FAIL rst_regs got %0d/%h exp 0/000000", bus.grant_id, bus.read_address); else pass_cnt++;
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rready = 1'b1; bus.m_axi_rdata = 32'h77777777;
        @(negedge clk);
        stray = bus.rsp_valid;
        rst = 1'b0;
        @(negedge clk);
        stray = stray | bus.rsp_valid;
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rdata = '0;
        @(negedge clk);
        stray = stray | bus.rsp_valid;
        total_cnt++; if (stray !== 4'b0000) $display("FAIL rst_no_rsp got %b exp 0000", stray); else pass_cnt++;
        post_req(3, 1'b0, 24'h000300, 32'h0);
        wait_ready(rdy, g, wp, rp, c);
        total_cnt++; if (g !== 3 || rdy !== 4'b1000) $display("FAIL rst_post_grant got %0d/%b exp 3/1000", g, rdy); else pass_cnt++;
        bus.req_valid = bus.req_valid & ~rdy;
        finish_cmd(1'b0, 32'h0BADCAFE, 2'b00, 2, pa, rv, rd, rr, rt);
        total_cnt++; if (rv !== 4'b1000 || rd !== 32'h0BADCAFE) $display("FAIL rst_post_rsp got %b/%h exp 1000/0badcafe", rv, rd); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] rdy, rv; int g; logic wp, rp, pa, rt; logic [DW-1:0] rd; logic [1:0] rr;
        int c[2];
        post_req(0, 1'b0, 24'h000080, 32'h0);
        for (int k = 0; k < 2; k++) begin
            wait_ready(rdy, g, wp, rp, c[k]);
            total_cnt++; if (g !== 0 || rp !== 1'b1) $display("FAIL b2b%0d grant got %0d/%b exp 0/1", k, g, rp); else pass_cnt++;
            finish_cmd(1'b0, 32'h100 + k, 2'b00, 0, pa, rv, rd, rr, rt);
            total_cnt++; if (pa !== 1'b0) $display("FAIL b2b%0d pulse_width got %b exp 0", k, pa); else pass_cnt++;
            total_cnt++; if (rv !== 4'b0001 || rd !== 32'h100 + k) $display("FAIL b2b%0d rsp got %b/%h exp 0001/%h", k, rv, rd, 32'h100 + k); else pass_cnt++;
        end
        bus.req_valid = '0;
        total_cnt++; if (c[0] < 0 || c[1] < 0 || c[1] - c[0] < 4) $display("FAIL b2b_spacing got %0d exp >=4", c[1] - c[0]); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bready = 1'b0; bus.m_axi_bresp = 2'b00;
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rready = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;
        test_reset();
        test_write();
        test_write_read();
        test_round_robin();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
